// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl
//   Sequencer between the control unit and the sequential multiply/divide
//   units. Latches operands on op_start, launches the selected unit with a
//   one-cycle start pulse, waits for its done (with a timeout), stages the
//   result and commits it to the architectural HI/LO registers. Division by
//   zero is trapped before launch. Also services direct HI/LO writes.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   op_start/op_sel     request from control unit (op_sel 0 = div, 1 = mult)
//   rs_val/rt_val       operands (dividend/multiplicand, divisor/multiplier)
//   mt_we/mt_sel/mt_data  direct HI (mt_sel=1) / LO (mt_sel=0) write
//   MDControl, dividendo, divisor    divider launch interface
//   div_done, div_quo, div_rem       divider result interface
//   mult_start, mult_a, mult_b       multiplier launch interface
//   mult_done, mult_hi, mult_lo      multiplier result interface
//   hi, lo              architectural HI/LO
//   busy                stall request (high whenever not IDLE)
//   div_zero, md_err    one-cycle divide-by-zero / timeout pulses
module md_hilo_ctrl #(
   parameter int TIMEOUT = 40,  // must exceed divider worst-case latency
   parameter int CNT_W   = 6    // 2**CNT_W must exceed TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_start,
   input  logic        op_sel,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mt_we,
   input  logic        mt_sel,
   input  logic [31:0] mt_data,
   output logic        MDControl,
   output logic [31:0] dividendo,
   output logic [31:0] divisor,
   input  logic        div_done,
   input  logic [31:0] div_quo,
   input  logic [31:0] div_rem,
   output logic        mult_start,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic        mult_done,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        div_zero,
   output logic        md_err
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [31:0]      rs_q, rs_d, rt_q, rt_d;
   logic             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      stg_hi_q, stg_hi_d, stg_lo_q, stg_lo_d;
   logic             div_zero_q, div_zero_d, md_err_q, md_err_d;
   logic             unit_done;

   // Only the launched unit's done is honoured; the other one is ignored.
   assign unit_done = sel_q ? mult_done : div_done;

   always_comb begin
      state_d    = state_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      stg_hi_d   = stg_hi_q;
      stg_lo_d   = stg_lo_q;
      div_zero_d = 1'b0;
      md_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op_start) begin
               // op_start has priority; a simultaneous mt write is dropped.
               rs_d  = rs_val;
               rt_d  = rt_val;
               sel_d = op_sel;
               if (!op_sel && (rt_val == 32'd0)) div_zero_d = 1'b1;
               else                              state_d    = S_LAUNCH;
            end else if (mt_we) begin
               if (mt_sel) hi_d = mt_data;
               else        lo_d = mt_data;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A done arriving on the last allowed cycle still wins over timeout.
            if (unit_done) begin
               stg_hi_d = sel_q ? mult_hi : div_rem;
               stg_lo_d = sel_q ? mult_lo : div_quo;
               state_d  = S_COMMIT;
            end else if (cnt_q == CNT_LAST) begin
               md_err_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_COMMIT: begin
            hi_d    = stg_hi_q;
            lo_d    = stg_lo_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rs_q       <= '0;
         rt_q       <= '0;
         sel_q      <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         stg_hi_q   <= '0;
         stg_lo_q   <= '0;
         div_zero_q <= 1'b0;
         md_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         stg_hi_q   <= stg_hi_d;
         stg_lo_q   <= stg_lo_d;
         div_zero_q <= div_zero_d;
         md_err_q   <= md_err_d;
      end
   end

   // Start pulses decode straight from state: LAUNCH lasts exactly one cycle.
   assign MDControl  = (state_q == S_LAUNCH) && !sel_q;
   assign mult_start = (state_q == S_LAUNCH) &&  sel_q;
   assign busy       = (state_q != S_IDLE);
   assign dividendo  = rs_q;
   assign divisor    = rt_q;
   assign mult_a     = rs_q;
   assign mult_b     = rt_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign div_zero   = div_zero_q;
   assign md_err     = md_err_q;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
module tb_md_hilo_ctrl;
   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_start, op_sel, mt_we, mt_sel;
   logic [31:0] rs_val, rt_val, mt_data;
   logic        MDControl, mult_start, busy, div_zero, md_err;
   logic [31:0] dividendo, divisor, mult_a, mult_b, hi, lo;
   logic        div_done, mult_done;
   logic [31:0] div_quo, div_rem, mult_hi, mult_lo;

   always #5 clk = ~clk;

   md_hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clk(clk), .reset(reset),
      .op_start(op_start), .op_sel(op_sel), .rs_val(rs_val), .rt_val(rt_val),
      .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
      .MDControl(MDControl), .dividendo(dividendo), .divisor(divisor),
      .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .hi(hi), .lo(lo), .busy(busy), .div_zero(div_zero), .md_err(md_err)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] m_hi, m_lo;   // expected architectural HI/LO

   // extra flags: [0] stray done from the other unit at cycle 3,
   // [1] garbage done from the selected unit during LAUNCH,
   // [2] mt_we during WAIT (cycle 2), [3] mt_we together with op_start
   typedef struct {
      logic        sel;
      logic [31:0] rs, rt;
      int          k;           // cycle in which the unit raises done
      logic [31:0] r_hi, r_lo;  // unit result: div rem/quo or mult hi/lo
      logic [3:0]  extra;
      logic [31:0] e_hi, e_lo;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_done(input vec_t v);
      if (v.sel) begin
         mult_done = 1'b1; mult_hi = v.r_hi; mult_lo = v.r_lo;
      end else begin
         div_done = 1'b1; div_rem = v.r_hi; div_quo = v.r_lo;
      end
   endtask

   // op_start in cycle 0, start pulse in cycle 1, done in cycle k,
   // result visible with busy low in cycle k+2.
   task automatic do_op(input string tag, input vec_t v);
      op_start = 1'b1; op_sel = v.sel; rs_val = v.rs; rt_val = v.rt;
      if (v.extra[3]) begin mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h1234_5678; end
      step();                                          // cycle 1: LAUNCH
      op_start = 1'b0; mt_we = 1'b0;
      rs_val = ~v.rs; rt_val = ~v.rt;                  // operands must be held
      chk1({tag, " launch busy"}, busy, 1'b1);
      chk1({tag, " MDControl"}, MDControl, ~v.sel);
      chk1({tag, " mult_start"}, mult_start, v.sel);
      chk({tag, " dividendo"}, dividendo, v.rs);
      chk({tag, " divisor"}, divisor, v.rt);
      chk({tag, " mult_a"}, mult_a, v.rs);
      chk({tag, " mult_b"}, mult_b, v.rt);
      if (v.extra[3]) chk({tag, " mt dropped lo"}, lo, m_lo);
      if (v.extra[1]) begin
         if (v.sel) begin mult_done = 1'b1; mult_hi = 32'hCCCC_CCCC; mult_lo = 32'hCCCC_CCCC; end
         else       begin div_done  = 1'b1; div_rem = 32'hCCCC_CCCC; div_quo = 32'hCCCC_CCCC; end
      end
      for (int c = 2; c <= v.k; c++) begin
         step();
         div_done = 1'b0; mult_done = 1'b0; mt_we = 1'b0;
         chk1({tag, " wait busy"}, busy, 1'b1);
         chk1({tag, " wait pulse"}, MDControl | mult_start, 1'b0);
         if (c == 2 && v.extra[2]) begin mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hBAD0_BAD0; end
         if (c == 3 && v.extra[2]) chk({tag, " mt while busy"}, hi, m_hi);
         if (c == 3 && v.extra[0]) begin
            if (v.sel) begin div_done = 1'b1; div_rem = 32'h5555_5555; div_quo = 32'hAAAA_AAAA; end
            else begin mult_done = 1'b1; mult_hi = 32'h5555_5555; mult_lo = 32'hAAAA_AAAA; end
         end
         if (c == v.k) begin
            chk({tag, " operand hold"}, dividendo, v.rs);
            drive_done(v);
         end
      end
      step();                                          // cycle k+1: COMMIT
      div_done = 1'b0; mult_done = 1'b0;
      chk1({tag, " commit busy"}, busy, 1'b1);
      chk({tag, " hi before commit"}, hi, m_hi);
      step();                                          // cycle k+2
      chk1({tag, " done busy"}, busy, 1'b0);
      chk({tag, " hi"}, hi, v.e_hi);
      chk({tag, " lo"}, lo, v.e_lo);
      chk1({tag, " no err"}, div_zero | md_err, 1'b0);
      m_hi = v.e_hi; m_lo = v.e_lo;
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'd10, 32'd2, 33, 32'd0, 32'd5, 4'h0, 32'd0, 32'd5};
      vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE, 4'h1, 32'h1, 32'hFFFF_FFFE};
      vecs[2] = '{1'b0, 32'd7, 32'd3, 2, 32'd1, 32'd2, 4'h0, 32'd1, 32'd2};
      vecs[3] = '{1'b1, 32'd3, 32'd4, 6, 32'd0, 32'd12, 4'h2, 32'd0, 32'd12};
      vecs[4] = '{1'b0, 32'd100, 32'd7, 8, 32'd2, 32'd14, 4'h5, 32'd2, 32'd14};
      vecs[5] = '{1'b1, 32'd2, 32'd3, 4, 32'd0, 32'd6, 4'h8, 32'd0, 32'd6};

      op_start = 0; op_sel = 0; rs_val = 0; rt_val = 0;
      mt_we = 0; mt_sel = 0; mt_data = 0;
      div_done = 0; div_quo = 0; div_rem = 0;
      mult_done = 0; mult_hi = 0; mult_lo = 0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      chk("reset dividendo", dividendo, 32'd0);
      chk("reset mult_b", mult_b, 32'd0);
      chk1("reset busy", busy, 1'b0);
      chk1("reset pulses", MDControl | mult_start | div_zero | md_err, 1'b0);
      step(); step();
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;

      // direct HI/LO writes
      mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hDEAD_BEEF;
      step();
      mt_sel = 1'b0; mt_data = 32'h0BAD_F00D;
      chk("mthi", hi, 32'hDEAD_BEEF);
      chk("mthi lo untouched", lo, 32'd0);
      step();
      mt_we = 1'b0;
      chk("mtlo", lo, 32'h0BAD_F00D);
      chk1("mt busy", busy, 1'b0);
      m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;

      foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i]);

      // divide by zero: trapped, no launch
      op_start = 1'b1; op_sel = 1'b0; rs_val = 32'd55; rt_val = 32'd0;
      step();
      op_start = 1'b0;
      chk1("dz pulse", div_zero, 1'b1);
      chk1("dz busy", busy, 1'b0);
      chk1("dz MDControl", MDControl, 1'b0);
      step();
      chk1("dz pulse end", div_zero, 1'b0);
      chk1("dz no launch", MDControl | busy, 1'b0);
      chk("dz hi", hi, m_hi);
      chk("dz lo", lo, m_lo);

      // timeout: TIMEOUT cycles in WAIT (cycles 2..TIMEOUT+1), no done
      op_start = 1'b1; op_sel = 1'b0; rs_val = 32'd9; rt_val = 32'd3;
      step();
      op_start = 1'b0;
      chk1("to MDControl", MDControl, 1'b1);
      for (int c = 2; c <= TIMEOUT + 1; c++) begin
         step();
         mt_we = 1'b0;
         chk1("to wait busy", busy, 1'b1);
         chk1("to early err", md_err, 1'b0);
         if (c == 10) begin mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h77; end
      end
      step();
      chk1("to md_err", md_err, 1'b1);
      chk1("to busy drop", busy, 1'b0);
      chk("to hi", hi, m_hi);
      chk("to lo", lo, m_lo);
      step();
      chk1("to md_err end", md_err, 1'b0);

      // asynchronous reset in the 10th WAIT cycle
      op_start = 1'b1; op_sel = 1'b0; rs_val = 32'd100; rt_val = 32'd5;
      step();
      op_start = 1'b0;
      for (int c = 2; c <= 11; c++) step();
      reset = 1'b0;
      #1;
      chk1("ar busy", busy, 1'b0);
      chk("ar hi", hi, 32'd0);
      chk("ar lo", lo, 32'd0);
      chk("ar dividendo", dividendo, 32'd0);
      chk("ar divisor", divisor, 32'd0);
      chk1("ar pulses", MDControl | mult_start | div_zero | md_err, 1'b0);
      step(); step();
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      step();
      chk1("ar no pulse after", MDControl | div_zero | md_err | busy, 1'b0);
      do_op("post reset", '{1'b0, 32'd100, 32'd5, 7, 32'd0, 32'd20, 4'h0, 32'd0, 32'd20});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
